// File: rtl/seq_pkg.sv
// Shared types and constants for the data-path sequencer: state encoding,
// mux-select meanings and the bundle of decoded control outputs.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_A    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Register selects (s0/s1), adder source (s2) and write source (s3).
    localparam logic SEL_HOLD = 1'b1;
    localparam logic SEL_LOAD = 1'b0;
    localparam logic SRC_R0   = 1'b0;
    localparam logic SRC_R1   = 1'b1;
    localparam logic WR_S2    = 1'b0;
    localparam logic WR_ACC   = 1'b1;

    typedef struct packed {
        logic dp_reset;
        logic s0;
        logic s1;
        logic s2;
        logic s3;
        logic busy;
        logic done;
    } seq_out_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter holding the remaining A/B iteration count.
// Synchronous active-high reset; never decrements below zero.
module seq_down_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic                 dec_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    output logic                 is_zero_o,
    output logic                 is_one_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !is_zero_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero_o = (cnt_q == '0);
    assign is_one_o  = (cnt_q == CNT_WIDTH'(1));

endmodule

// File: rtl/datapath_sequencer.sv
// Moore control FSM driving the mux/adder/register data path (s0..s3, dp_reset).
// Optional `SEQ_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] n_iter,
    output logic                 dp_reset,
    output logic                 s0,
    output logic                 s1,
    output logic                 s2,
    output logic                 s3,
    output logic                 busy,
    output logic                 done
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]          cycles
`endif
);

    state_e   state_q, state_d;
    seq_out_t out;
    logic     cnt_load, cnt_dec, cnt_is_zero, cnt_is_one;

    seq_down_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk_i      (Clk),
        .reset_i    (reset),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (n_iter),
        .is_zero_o  (cnt_is_zero),
        .is_one_o   (cnt_is_one)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_INIT;
                    cnt_load = 1'b1;
                end
            end
            ST_INIT: state_d = cnt_is_zero ? ST_DONE : ST_A;
            ST_A:    state_d = ST_B;
            ST_B: begin
                if (cnt_is_one) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_A;
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs depend on the registered state only.
    always_comb begin
        out = '{dp_reset: 1'b0, s0: SEL_HOLD, s1: SEL_HOLD, s2: SRC_R0,
                s3: WR_S2, busy: 1'b0, done: 1'b0};
        unique case (state_q)
            ST_IDLE: ;
            ST_INIT: begin
                out.dp_reset = 1'b1;
                out.busy     = 1'b1;
            end
            ST_A: begin
                out.s0   = SEL_LOAD;
                out.s2   = SRC_R1;
                out.s3   = WR_ACC;
                out.busy = 1'b1;
            end
            ST_B: begin
                out.s1   = SEL_LOAD;
                out.busy = 1'b1;
            end
            ST_DONE: out.done = 1'b1;
            default: ;
        endcase
    end

    assign dp_reset = out.dp_reset;
    assign s0       = out.s0;
    assign s1       = out.s1;
    assign s2       = out.s2;
    assign s3       = out.s3;
    assign busy     = out.busy;
    assign done     = out.done;

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (cnt_load) begin
            cycles_d = '0;
        end else if (out.busy && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule
